seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Parametrised successor to the fixed 4-digit hex display LUT used on the DE-series boards.
- Drives N seven-segment digits from a packed hex value loaded by a strobe.
- Two output modes:
  - static: one 7-bit bus per digit, as on the DE2 HEX pins;
  - scanned: a shared segment bus plus digit enables, for GPIO daughterboards.
- Adds leading-zero suppression, per-digit blanking and blinking, and tear-free frame-synchronous updates.
- Sits in the board toplevel between the ZPUTest counter/register outputs and the display pins.

Parameters:
- DIGITS, 8, number of digits (1..16).
- SCANNED, 0, 0 = static parallel outputs; 1 = time-multiplexed scan.
- SCAN_DIV, 16384, clk cycles per digit slot (>=2).
- BLINK_FRAMES, 64, frames per blink half-period (>=1).

Ports:
- clk, in, 1, system clock (clk133 domain).
- reset_in, in, 1, asynchronous active-low reset.
- value, in, 4*DIGITS, hex nibbles; nibble 0 is the rightmost digit.
- blank_mask, in, DIGITS, 1 = digit forced dark.
- blink_mask, in, DIGITS, 1 = digit blinks.
- lz_suppress, in, 1, enables leading-zero suppression.
- load, in, 1, single-cycle strobe; captures value, blank_mask, blink_mask, lz_suppress.
- pending, out, 1, captured data not yet applied to the display.
- frame_tick, out, 1, one-cycle pulse at each frame boundary.
- seg_static, out, 7*DIGITS, active-low segments per digit (bit0=a … bit6=g); all 7'h7F when SCANNED=1.
- seg_scan, out, 7, active-low shared segment bus; 7'h7F when SCANNED=0.
- dig_en, out, DIGITS, active-low one-hot digit enable; all ones when SCANNED=0.

Behaviour:
- Reset (async, reset_in low):
  - seg_static all 7'h7F, seg_scan 7'h7F, dig_en all ones;
  - pending 0, frame_tick 0;
  - shadow and active registers 0, prescaler 0, digit index 0, blink counter 0, blink phase 0.
  - Reset asserted mid-scan or mid-pending discards all state.
- Prescaler: counts 0..SCAN_DIV-1 in both modes.
  - At terminal count, digit index advances 0..DIGITS-1, wrapping to 0.
  - The wrap from DIGITS-1 to 0 is the frame boundary: frame_tick is high for exactly that cycle.
- Blink:
  - Blink counter counts frames 0..BLINK_FRAMES-1.
  - At its terminal count on a frame boundary, blink phase toggles.
  - Phase 1 blanks digits whose active blink_mask bit is set.
- Load handshake:
  - load at edge k captures inputs into shadow registers and sets pending at edge k.
  - SCANNED=0: shadow copies to active at edge k+1 and pending clears at k+1.
  - SCANNED=1: the copy happens on the next frame-boundary edge; pending clears on that edge.
  - load while pending: shadow is overwritten, pending stays 1; the last load before the boundary wins.
  - load coinciding with the boundary edge: the old shadow is applied and the new data captured; pending stays 1 until the next boundary.
- Digit content priority, highest first:
  - blank_mask → 7'h7F;
  - blink phase with blink_mask → 7'h7F;
  - leading-zero → 7'h7F;
  - hex decode.
- Leading-zero suppression: scanning from digit DIGITS-1 downward, zero nibbles are blanked until the first nonzero nibble. Digit 0 is never suppressed.
- Decode (standard active-low): 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, F→7'h0E.
- Output timing: all outputs are registered, one cycle after the active state, index, or phase changes.
- Scanned mode ghosting guard:
  - for the first cycle of each digit slot, dig_en is all ones;
  - seg_scan already shows the new digit during that cycle;
  - dig_en[index] goes low from the second cycle of the slot.
- DIGITS=1 in scanned mode: every slot end is a frame boundary.

Optional Feature:
- Macro: SEG7_DP_EN.
- Defined:
  - adds input dp_mask[DIGITS] (captured by load, applied like value) and outputs dp_static[DIGITS] and dp_scan (active low);
  - decimal point is lit only when the digit is not blanked by blank_mask or blink phase;
  - leading-zero suppression does not hide a lit decimal point.
- Undefined: these ports and their registers do not exist.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F;
  - the 16-entry hex-to-segment constant table;
  - a function hex_to_seg(nibble).
- Sub-module seg7_decode: combinational nibble plus blank/lz qualifier → 7-bit pattern; instantiated DIGITS times (static) or once (scanned).
- Prescaler, scan index, blink logic and handshake stay in seg7_scan_driver.

Test Plan:
- DIGITS=4, SCANNED=0, reset release, load value=16'h12AF → seg_static={7'h79,7'h24,7'h08,7'h0E} two edges after the load edge; pending high for exactly one cycle.
- DIGITS=4, lz_suppress=1, value=16'h0030 → digits 3,2 = 7'h7F, digit1 = 7'h30, digit0 = 7'h40; value=16'h0000 → only digit0 lit (7'h40).
- DIGITS=4, SCANNED=1, SCAN_DIV=4:
  - dig_en low sequence 1110,1101,1011,0111 with a one-cycle all-ones guard per slot;
  - frame_tick every 16 cycles.
- SCANNED=1:
  - load 16'h1111 mid-frame then 16'h2222 before the boundary → display never shows 1s, shows 2s from the boundary;
  - pending cleared on the boundary edge.
- BLINK_FRAMES=2, blink_mask=4'b0001, blank_mask=4'b1000 → digit0 alternates lit/7'h7F every 2 frames; digit3 always 7'h7F.
- Assert reset_in low mid-pending in scanned mode → all outputs go to reset values immediately; previous value not restored after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment display driver.
// Segment patterns are active low, bit0 = a ... bit6 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: one digit worth of segment pattern. Both qualifiers darken the
// digit, so their relative priority does not matter here.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  input  logic       i_lz,
  output logic [6:0] o_seg
);

  assign o_seg = (i_blank || i_lz) ? SEG_BLANK : hex_to_seg(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: N-digit hex display driver, static or scanned outputs.
// Loads land in a shadow set and are copied to the active set immediately
// (static) or on the next frame boundary (scanned) so a frame never tears.
// Optional decimal points: define SEG7_DP_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCANNED      = 0,
  parameter int SCAN_DIV     = 16384,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_suppress,
  input  logic                  load,
`ifdef SEG7_DP_EN
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     dp_static,
  output logic                  dp_scan,
`endif
  output logic                  pending,
  output logic                  frame_tick,
  output logic [7*DIGITS-1:0]   seg_static,
  output logic [6:0]            seg_scan,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_phase;
  logic                  r_frame_tick;
  logic                  r_pending;
  logic [4*DIGITS-1:0]   r_sh_value,  r_act_value;
  logic [DIGITS-1:0]     r_sh_blank,  r_act_blank;
  logic [DIGITS-1:0]     r_sh_blink,  r_act_blink;
  logic                  r_sh_lz,     r_act_lz;
  logic [7*DIGITS-1:0]   r_seg_static;
  logic [6:0]            r_seg_scan;
  logic [DIGITS-1:0]     r_dig_en;

  logic                  w_presc_tc;
  logic                  w_frame;
  logic                  w_apply;
  logic [DIGITS-1:0]     w_dark;
  logic [DIGITS-1:0]     w_lz;
  logic [7*DIGITS-1:0]   w_seg_all;
  logic [6:0]            w_seg_one;

  assign w_presc_tc = (r_presc == PRESC_TC);
  assign w_frame    = w_presc_tc && (r_idx == IDX_LAST);
  // Static mode has no tearing to avoid, so the copy happens on the next edge.
  assign w_apply    = r_pending && ((SCANNED == 0) || w_frame);
  assign w_dark     = r_act_blank | (r_act_blink & {DIGITS{r_blink_phase}});

  // Slot prescaler, digit index and frame pulse.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame;
      if (w_presc_tc) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Blink phase flips every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame) begin
      if (r_blink_cnt == BLINK_TC) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Shadow/active handshake; a load on the apply edge still applies the old shadow.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_sh_value  <= '0;
      r_sh_blank  <= '0;
      r_sh_blink  <= '0;
      r_sh_lz     <= 1'b0;
      r_act_value <= '0;
      r_act_blank <= '0;
      r_act_blink <= '0;
      r_act_lz    <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_value <= r_sh_value;
        r_act_blank <= r_sh_blank;
        r_act_blink <= r_sh_blink;
        r_act_lz    <= r_sh_lz;
      end
      if (load) begin
        r_sh_value <= value;
        r_sh_blank <= blank_mask;
        r_sh_blink <= blink_mask;
        r_sh_lz    <= lz_suppress;
        r_pending  <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Leading zeros: walk down from the top digit until the first nonzero nibble.
  always_comb begin
    logic v_seen;
    v_seen = 1'b0;
    w_lz   = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (r_act_value[4*d +: 4] != 4'h0) v_seen = 1'b1;
      w_lz[d] = r_act_lz && !v_seen && (d != 0);
    end
  end

  generate
    if (SCANNED == 0) begin : g_static
      for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        seg7_decode u_dec (
          .i_nibble (r_act_value[4*d +: 4]),
          .i_blank  (w_dark[d]),
          .i_lz     (w_lz[d]),
          .o_seg    (w_seg_all[7*d +: 7])
        );
      end
      assign w_seg_one = SEG_BLANK;
    end else begin : g_scan
      seg7_decode u_dec (
        .i_nibble (r_act_value[4*r_idx +: 4]),
        .i_blank  (w_dark[r_idx]),
        .i_lz     (w_lz[r_idx]),
        .o_seg    (w_seg_one)
      );
      assign w_seg_all = '1;
    end
  endgenerate

  // Registered pins; the first cycle of every slot keeps all digits off to avoid ghosting.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_seg_static <= {DIGITS{SEG_BLANK}};
      r_seg_scan   <= SEG_BLANK;
      r_dig_en     <= '1;
    end else if (SCANNED == 0) begin
      r_seg_static <= w_seg_all;
      r_seg_scan   <= SEG_BLANK;
      r_dig_en     <= '1;
    end else begin
      r_seg_static <= {DIGITS{SEG_BLANK}};
      r_seg_scan   <= w_seg_one;
      r_dig_en     <= (r_presc == '0) ? '1 : ~(DIGITS'(1) << r_idx);
    end
  end

`ifdef SEG7_DP_EN
  logic [DIGITS-1:0] r_sh_dp, r_act_dp, r_dp_static;
  logic              r_dp_scan;
  logic [DIGITS-1:0] w_dp_on;

  // Leading-zero suppression deliberately does not hide a lit point.
  assign w_dp_on = r_act_dp & ~w_dark;

  // Decimal points follow the same shadow/active handshake as the digits.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_sh_dp     <= '0;
      r_act_dp    <= '0;
      r_dp_static <= '1;
      r_dp_scan   <= 1'b1;
    end else begin
      if (w_apply) r_act_dp <= r_sh_dp;
      if (load)    r_sh_dp  <= dp_mask;
      r_dp_static <= (SCANNED == 0) ? ~w_dp_on : '1;
      r_dp_scan   <= (SCANNED == 0) ? 1'b1 : ~w_dp_on[r_idx];
    end
  end

  assign dp_static = r_dp_static;
  assign dp_scan   = r_dp_scan;
`endif

  assign pending    = r_pending;
  assign frame_tick = r_frame_tick;
  assign seg_static = r_seg_static;
  assign seg_scan   = r_seg_scan;
  assign dig_en     = r_dig_en;

endmodule
